// File: rtl/dma_copy_master.sv
// Word-granular memory-to-memory copy engine with an MMIO register window
// and a PicoRV32-style valid/ready bus master.
module dma_copy_master #(
    parameter int MAX_LEN_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mmio_wr,
    input  logic        mmio_rd,
    input  logic [15:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic [3:0]  mmio_wstrb,
    output logic [31:0] mmio_rdata,
    output logic        mmio_ready,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        done_irq
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_src_ptr;
    logic [31:0]          r_dst_ptr;
    logic [31:0]          r_buf;
    logic [MAX_LEN_W-1:0] r_len;
    logic [MAX_LEN_W-1:0] r_count;
    logic                 r_done;
    logic                 r_err;
    logic                 r_aborted;
    logic                 r_abort_req;

    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_start;
    logic        w_abort;
    logic        w_stop;
    logic [31:0] w_rdata;

    // Side effects fire only on the edge that raises mmio_ready.
    assign w_acc    = (mmio_wr | mmio_rd) & ~mmio_ready;
    assign w_wr     = w_acc & mmio_wr & (|mmio_wstrb);
    assign w_rd     = w_acc & mmio_rd;
    assign w_busy   = (r_state != S_IDLE);
    assign w_start  = w_wr && (mmio_addr == 16'h0000) && mmio_wdata[0];
    assign w_abort  = w_wr && (mmio_addr == 16'h0000) && mmio_wdata[1];
    assign w_stop   = r_abort_req | w_abort;
    assign done_irq = r_done;

    always_comb begin
        w_rdata = '0;
        case (mmio_addr)
            16'h0004: w_rdata[3:0] = {r_aborted, r_err, r_done, w_busy};
            16'h0008: w_rdata = r_src;
            16'h000C: w_rdata = r_dst;
            16'h0010: w_rdata[MAX_LEN_W-1:0] = r_len;
            16'h0014: w_rdata[MAX_LEN_W-1:0] = r_count;
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_buf       <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_aborted   <= 1'b0;
            r_abort_req <= 1'b0;
            mmio_ready  <= 1'b0;
            mmio_rdata  <= '0;
            m_valid     <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
        end else begin
            mmio_ready <= (mmio_wr | mmio_rd) & ~mmio_ready;
            mmio_rdata <= w_rd ? w_rdata : '0;

            if (w_wr && mmio_addr == 16'h0004) begin
                if (mmio_wdata[1]) r_done    <= 1'b0;
                if (mmio_wdata[2]) r_err     <= 1'b0;
                if (mmio_wdata[3]) r_aborted <= 1'b0;
            end

            if (w_wr && !w_busy) begin
                case (mmio_addr)
                    16'h0008: r_src <= mmio_wdata;
                    16'h000C: r_dst <= mmio_wdata;
                    16'h0010: r_len <= mmio_wdata[MAX_LEN_W-1:0];
                    default:  ;
                endcase
            end

            unique case (r_state)
                S_IDLE: begin
                    r_abort_req <= 1'b0;
                    if (w_start) begin
                        if (r_src[1:0] != 2'b00 || r_dst[1:0] != 2'b00) begin
                            r_err <= 1'b1;
                        end else if (r_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_src_ptr <= r_src;
                            r_dst_ptr <= r_dst;
                            r_count   <= r_len;
                            r_done    <= 1'b0;
                            r_err     <= 1'b0;
                            r_aborted <= 1'b0;
                            r_state   <= S_RD;
                        end
                    end
                end
                S_RD, S_WR: begin
                    if (w_abort) r_abort_req <= 1'b1;
                    if (!m_valid) begin
                        // Abort seen in the idle gap: no new request is issued.
                        if (w_stop) begin
                            r_state     <= S_IDLE;
                            r_aborted   <= 1'b1;
                            r_abort_req <= 1'b0;
                        end else begin
                            m_valid <= 1'b1;
                            if (r_state == S_RD) begin
                                m_addr  <= r_src_ptr;
                                m_wstrb <= 4'b0000;
                            end else begin
                                m_addr  <= r_dst_ptr;
                                m_wdata <= r_buf;
                                m_wstrb <= 4'b1111;
                            end
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        if (r_state == S_RD) begin
                            r_buf     <= m_rdata;
                            r_src_ptr <= r_src_ptr + 32'd4;
                        end else begin
                            r_dst_ptr <= r_dst_ptr + 32'd4;
                            r_count   <= r_count - 1'b1;
                        end
                        if (w_stop) begin
                            r_state     <= S_IDLE;
                            r_aborted   <= 1'b1;
                            r_abort_req <= 1'b0;
                        end else if (r_state == S_RD) begin
                            r_state <= S_WR;
                        end else if (r_count == MAX_LEN_W'(1)) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dma_copy_master.md
# dma_copy_master

Word-granular memory-to-memory copy engine and the initiator counterpart of the SoC memory interconnect. Firmware programs it through an MMIO responder port, decoded by the SoC like the TPU window. It then masters a PicoRV32-native memory bus (valid/ready, wstrb=0 for read) that is arbitrated into the RAM/TPU fabric. It reads one word from SRC, writes it to DST, and repeats for LEN words, signalling completion by a sticky status bit and a level IRQ.

## Interface
- MAX_LEN_W, 16: width of LEN and COUNT registers; maximum copy is 2^MAX_LEN_W-1 words.
- clk  in  1  single clock, all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- mmio_wr  in  1  MMIO write request, held until mmio_ready.
- mmio_rd  in  1  MMIO read request, held until mmio_ready.
- mmio_addr  in  16  byte offset within window.
- mmio_wdata  in  32  write data.
- mmio_wstrb  in  4  byte strobes; any nonzero strobe writes the full register.
- mmio_rdata  out  32  read data, valid while mmio_ready=1.
- mmio_ready  out  1  one-cycle completion pulse.
- m_valid  out  1  master request.
- m_addr  out  32  master byte address, word aligned.
- m_wdata  out  32  master write data.
- m_wstrb  out  4  0000 = read, 1111 = write.
- m_ready  in  1  responder completion.
- m_rdata  in  32  responder read data, sampled on the m_valid&m_ready edge.
- done_irq  out  1  equals STATUS.DONE.

## Operation
- Register map:
  - 0x00 CTRL, write-only: bit0 START, bit1 ABORT (write-1 pulses).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE, bit2 ERR, bit3 ABORTED (sticky, write-1-to-clear).
  - 0x08 SRC.
  - 0x0C DST.
  - 0x10 LEN[MAX_LEN_W-1:0].
  - 0x14 COUNT, RO: words remaining.
  - Other offsets read 0; writes to them are ignored.
- SRC, DST and LEN writes are ignored while BUSY.
- FSM: IDLE, RD, WR.
- START in IDLE:
  - If SRC[1:0]!=0 or DST[1:0]!=0: set ERR, stay IDLE, no bus traffic.
  - Else if LEN==0: set DONE, stay IDLE.
  - Else: load src_ptr=SRC, dst_ptr=DST, COUNT=LEN, clear DONE/ERR/ABORTED, enter RD.
- START while BUSY is ignored. A START and a status clear in the same cycle are not possible: they are different offsets.
- RD:
  - Drive m_valid=1, m_addr=src_ptr, m_wstrb=0.
  - On the m_ready edge, capture m_rdata into a data buffer, src_ptr += 4, go to WR.
- WR:
  - Drive m_valid=1, m_addr=dst_ptr, m_wdata=buffer, m_wstrb=1111.
  - On the m_ready edge, dst_ptr += 4 and COUNT -= 1.
  - If COUNT was 1, go to IDLE and set DONE; else go to RD.
- Pointers wrap modulo 2^32 with no error.
- ABORT while BUSY:
  - Latched.
  - The in-flight transfer (m_valid already high) completes normally.
  - At its handshake the FSM goes to IDLE, sets ABORTED, does not set DONE, and COUNT keeps the remaining count.
- ABORT in IDLE: no effect.
- MMIO transaction rule: mmio_ready <= (mmio_wr|mmio_rd) & !mmio_ready. Register side effects occur on the same edge that raises mmio_ready, exactly once per transaction.

## Timing
- Reset (async assert, sync release):
  - FSM=IDLE; m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0.
  - mmio_ready=0, mmio_rdata=0.
  - All registers 0; done_irq=0.
  - Reset mid-copy abandons the bus immediately.
- m_valid, m_addr, m_wdata and m_wstrb are registered and stay stable while m_valid=1 && m_ready=0.
- m_valid deasserts on the handshake edge and stays low for exactly one cycle before the next request. Responders with registered ready must not see back-to-back valid.
- START to first m_valid: 1 cycle after the mmio_ready edge.
- Per word, with responder latency L (cycles from m_valid rise to m_ready): 2*(L+1) cycles.
- DONE and done_irq rise on the final write handshake edge. BUSY falls on the same edge.
- MMIO reads: mmio_rdata is registered alongside mmio_ready and holds its value 0 when ready=0.

## Test plan
- Copy 4 words with SRC=0x100, DST=0x200, LEN=4, and a 1-cycle-latency RAM model -> memory 0x200..0x20C equals 0x100..0x10C; exactly 8 handshakes; DONE=1 and done_irq=1 at cycle 16 after START.
- LEN=0 then START -> no m_valid ever; DONE=1 on the next read; STATUS reads 0x2. Write 0x2 to STATUS -> reads 0x0.
- SRC=0x102 then START -> ERR=1, BUSY=0, no bus traffic.
- LEN=100, ABORT issued while a write is stalled (m_ready held low 5 cycles) -> m_valid held stable through the stall, the write completes, then IDLE; ABORTED=1, DONE=0, COUNT=remaining.
- Random m_ready stalls of 0-7 cycles on a 64-word copy -> data correct; m_valid never high on two consecutive handshake cycles; address monotonic +4; SRC/DST/LEN writes mid-copy ignored.
- resetn pulsed low mid-transfer -> m_valid=0 asynchronously; all registers read 0 after release.
